// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared width type, default servo timing constants, clamp helper
package servo_pkg;

  typedef logic [15:0] width_t;

  localparam int DEF_W_MIN     = 1000;
  localparam int DEF_W_MAX     = 2000;
  localparam int DEF_W_NEUTRAL = 1500;
  localparam int DEF_FRAME_US  = 20000;
  localparam int DEF_STEP_US   = 20;

  function automatic width_t clamp_width(input width_t w, input width_t lo, input width_t hi);
    if (w < lo) return lo;
    if (w > hi) return hi;
    return w;
  endfunction

endpackage

// File: rtl/servo_ramp_ch.sv
// rtl/servo_ramp_ch.sv - one servo channel: target/current width ramp and PWM comparator
module servo_ramp_ch
  import servo_pkg::*;
#(
  parameter int W_NEUTRAL = DEF_W_NEUTRAL,
  parameter int STEP_US   = DEF_STEP_US
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  width_t      load_width,
  input  logic        frame_end,
  input  logic [31:0] frame_cnt,
  output logic        pwm,
  output logic        busy_ch
);

  localparam logic signed [16:0] STEP = 17'(STEP_US);

  width_t             cur;
  width_t             target;
  logic signed [16:0] diff;
  logic signed [16:0] next_cur;

  // Signed 17-bit difference keeps the step direction exact for any 16-bit pair.
  always_comb begin
    diff     = $signed({1'b0, target}) - $signed({1'b0, cur});
    next_cur = $signed({1'b0, target});
    if (diff > STEP)
      next_cur = $signed({1'b0, cur}) + STEP;
    else if (diff < -STEP)
      next_cur = $signed({1'b0, cur}) - STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur    <= 16'(W_NEUTRAL);
      target <= 16'(W_NEUTRAL);
      pwm    <= 1'b0;
    end else begin
      if (load)
        target <= load_width;
      if (frame_end)
        cur <= 16'(next_cur);
      pwm <= (frame_cnt < {16'd0, cur});
    end
  end

  assign busy_ch = (cur != target);

endmodule

// File: rtl/gesture_servo_ctrl.sv
// rtl/gesture_servo_ctrl.sv - gesture-table driven multi-channel servo PWM controller
module gesture_servo_ctrl
  import servo_pkg::*;
#(
  parameter int NUM_CH    = 5,
  parameter int NUM_GEST  = 8,
  parameter int CLK_HZ    = 50_000_000,
  parameter int FRAME_US  = DEF_FRAME_US,
  parameter int W_MIN     = DEF_W_MIN,
  parameter int W_MAX     = DEF_W_MAX,
  parameter int W_NEUTRAL = DEF_W_NEUTRAL,
  parameter int STEP_US   = DEF_STEP_US
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                gesture,
  input  logic                      gesture_valid,
  input  logic                      cfg_we,
  input  logic [7:0]                cfg_gest,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [15:0]               cfg_width,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic                      busy,
  output logic                      gest_err
);

  localparam logic [31:0] PRE_LAST   = 32'(CLK_HZ / 1_000_000 - 1);
  localparam logic [31:0] FRAME_LAST = 32'(FRAME_US - 1);
  localparam logic [31:0] NG_U       = 32'(NUM_GEST);
  localparam logic [31:0] NC_U       = 32'(NUM_CH);
  localparam int          GW         = (NUM_GEST > 1) ? $clog2(NUM_GEST) : 1;

  logic [31:0]       pre_cnt;
  logic [31:0]       frame_cnt;
  logic              tick;
  logic              frame_end;
  logic              cfg_ok;
  logic              gest_ok;
  logic [NUM_CH-1:0] busy_vec;
  width_t            tbl [NUM_GEST][NUM_CH];

  assign tick      = (pre_cnt == PRE_LAST);
  assign frame_end = tick && (frame_cnt == FRAME_LAST);
  assign cfg_ok    = ({24'd0, cfg_gest} < NG_U) && (32'(cfg_ch) < NC_U);
  assign gest_ok   = ({24'd0, gesture} < NG_U);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 32'd1;
      if (tick)
        frame_cnt <= frame_end ? '0 : frame_cnt + 32'd1;
    end
  end

  // Channels read the table combinationally, so a same-cycle write is not yet visible to a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NUM_GEST; g++)
        for (int c = 0; c < NUM_CH; c++)
          tbl[g][c] <= 16'(W_NEUTRAL);
    end else if (cfg_we && cfg_ok) begin
      tbl[cfg_gest[GW-1:0]][cfg_ch] <= clamp_width(cfg_width, 16'(W_MIN), 16'(W_MAX));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      gest_err <= 1'b0;
    else
      gest_err <= gesture_valid && !gest_ok;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    width_t ld_w;
    assign ld_w = gest_ok ? tbl[gesture[GW-1:0]][gi] : 16'(W_NEUTRAL);

    servo_ramp_ch #(
      .W_NEUTRAL (W_NEUTRAL),
      .STEP_US   (STEP_US)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .load       (gesture_valid),
      .load_width (ld_w),
      .frame_end  (frame_end),
      .frame_cnt  (frame_cnt),
      .pwm        (pwm_out[gi]),
      .busy_ch    (busy_vec[gi])
    );
  end

  assign busy = |busy_vec;

endmodule

// File: tb/tb_gesture_servo_ctrl.sv
// tb/tb_gesture_servo_ctrl.sv - randomized self-checking bench against a frame-level servo model
module tb_gesture_servo_ctrl;

  localparam int NCH = 5;
  localparam int NG  = 8;
  localparam int WMN = 20;
  localparam int WMX = 80;
  localparam int WNT = 50;
  localparam int STP = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [7:0]     gesture = '0;
  logic           gesture_valid = 1'b0;
  logic           cfg_we = 1'b0;
  logic [7:0]     cfg_gest = '0;
  logic [2:0]     cfg_ch = '0;
  logic [15:0]    cfg_width = '0;
  logic [NCH-1:0] pwm_out;
  logic           busy;
  logic           gest_err;

  int total = 0;
  int bad   = 0;

  int m_tbl [NG][NCH];
  int m_tgt [NCH];
  int m_cur [NCH];

  always #5 clk = ~clk;

  gesture_servo_ctrl #(
    .NUM_CH    (NCH),
    .NUM_GEST  (NG),
    .CLK_HZ    (2_000_000),
    .FRAME_US  (100),
    .W_MIN     (WMN),
    .W_MAX     (WMX),
    .W_NEUTRAL (WNT),
    .STEP_US   (STP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .gesture       (gesture),
    .gesture_valid (gesture_valid),
    .cfg_we        (cfg_we),
    .cfg_gest      (cfg_gest),
    .cfg_ch        (cfg_ch),
    .cfg_width     (cfg_width),
    .pwm_out       (pwm_out),
    .busy          (busy),
    .gest_err      (gest_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampw(input int w);
    if (w < WMN) return WMN;
    if (w > WMX) return WMX;
    return w;
  endfunction

  function automatic int m_busy();
    for (int i = 0; i < NCH; i++)
      if (m_cur[i] != m_tgt[i]) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NG; g++)
      for (int c = 0; c < NCH; c++)
        m_tbl[g][c] = WNT;
    for (int c = 0; c < NCH; c++) begin
      m_tgt[c] = WNT;
      m_cur[c] = WNT;
    end
  endtask

  task automatic model_frame_end();
    for (int c = 0; c < NCH; c++) begin
      int d;
      d = m_tgt[c] - m_cur[c];
      if (d > STP)       m_cur[c] += STP;
      else if (d < -STP) m_cur[c] -= STP;
      else               m_cur[c] = m_tgt[c];
    end
  endtask

  task automatic wait_rise();
    logic prev;
    int   n;
    prev = pwm_out[0];
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (!prev && pwm_out[0]) break;
      prev = pwm_out[0];
      if (n > 600) begin
        chk("frame_start_timeout", 0, 1);
        break;
      end
    end
    model_frame_end();
  endtask

  // Measure one full frame: each channel's high time must be 2 clocks per us of width.
  task automatic run_frame();
    int cnt [NCH];
    wait_rise();
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    for (int k = 0; k < 180; k++) begin
      for (int c = 0; c < NCH; c++) cnt[c] += int'(pwm_out[c]);
      @(negedge clk);
    end
    for (int c = 0; c < NCH; c++)
      chk($sformatf("pulse_ch%0d", c), cnt[c], 2 * m_cur[c]);
    chk("busy_frame", int'(busy), m_busy());
  endtask

  task automatic cyc(input logic we, input int cg, input int cc, input int cw,
                     input logic gv, input int g);
    int exp_err;
    cfg_we = we; cfg_gest = cg[7:0]; cfg_ch = cc[2:0]; cfg_width = cw[15:0];
    gesture_valid = gv; gesture = g[7:0];
    exp_err = (gv && g >= NG) ? 1 : 0;
    if (gv)
      for (int c = 0; c < NCH; c++)
        m_tgt[c] = (g < NG) ? m_tbl[g][c] : WNT;
    if (we && cg < NG && cc < NCH)
      m_tbl[cg][cc] = clampw(cw);
    @(negedge clk);
    cfg_we = 1'b0; gesture_valid = 1'b0;
    chk("gest_err", int'(gest_err), exp_err);
    chk("busy_load", int'(busy), m_busy());
    if (gv) begin
      @(negedge clk);
      chk("gest_err_clear", int'(gest_err), 0);
    end
  endtask

  task automatic write_all(input int g, input int w);
    for (int c = 0; c < NCH; c++) cyc(1'b1, g, c, w, 1'b0, 0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(gest_err), 0);
    rst = 1'b0;

    repeat (2) run_frame();

    write_all(1, 70);
    cyc(1'b0, 0, 0, 0, 1'b1, 1);
    repeat (4) run_frame();

    cyc(1'b0, 0, 0, 0, 1'b1, 9);
    repeat (4) run_frame();

    cyc(1'b0, 0, 0, 0, 1'b1, 1);
    repeat (2) run_frame();
    write_all(3, 40);
    cyc(1'b0, 0, 0, 0, 1'b1, 3);
    repeat (4) run_frame();

    cyc(1'b1, 2, 0, 200, 1'b0, 0);
    cyc(1'b1, 2, 0, 20, 1'b1, 2);
    repeat (6) run_frame();
    cyc(1'b0, 0, 0, 0, 1'b1, 2);

    wait_rise();
    repeat (20) @(negedge clk);
    chk("pwm_before_rst", int'(pwm_out), 31);
    chk("busy_before_rst", int'(busy), m_busy());
    #2 rst = 1'b1;
    #1;
    chk("pwm_async_rst", int'(pwm_out), 0);
    chk("busy_async_rst", int'(busy), 0);
    chk("err_async_rst", int'(gest_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("pwm_after_rst", int'(pwm_out), 0);
    repeat (2) run_frame();
    cyc(1'b0, 0, 0, 0, 1'b1, 1);

    for (int f = 0; f < 25; f++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++)
        cyc(1'b1, $urandom_range(0, 9), $urandom_range(0, 6),
            ($urandom_range(0, 3) == 0) ? 200 : $urandom_range(0, 255), 1'b0, 0);
      if ($urandom_range(0, 2) != 0)
        cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9), $urandom_range(0, 5),
            $urandom_range(0, 255), 1'b1, $urandom_range(0, 10));
      run_frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gesture_servo_ctrl.md
GESTURE_SERVO_CTRL -- requirements
Module: gesture_servo_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of servo channels (thumb..pinky = ch0..ch4).
REQ-002 SHALL have parameter NUM_GEST, default 8, number of gesture table entries.
REQ-003 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency.
REQ-004 SHALL have parameter FRAME_US, default 20000, PWM frame period in us.
REQ-005 SHALL have parameters W_MIN / W_MAX / W_NEUTRAL, defaults 1000 / 2000 / 1500, pulse-width limits and rest width in us.
REQ-006 SHALL have parameter STEP_US, default 20, maximum width change per channel per frame.
REQ-007 SHALL have port clk, input, 1, sole clock.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port gesture, input, 8, gesture code.
REQ-010 SHALL have port gesture_valid, input, 1, one-cycle strobe qualifying gesture.
REQ-011 SHALL have ports cfg_we (1), cfg_gest (8), cfg_ch ($clog2(NUM_CH)) and cfg_width (16), all inputs, table write port.
REQ-012 SHALL have port pwm_out, output, NUM_CH, servo pulse outputs.
REQ-013 SHALL have port busy, output, 1, high while any channel's current width differs from its target width.
REQ-014 SHALL have port gest_err, output, 1, one-cycle pulse on an out-of-range gesture.

Function
REQ-015 SHALL derive a 1 us tick from a prescaler counting 0..CLK_HZ/1_000_000-1, with the tick asserted for one cycle at terminal count.
REQ-016 SHALL keep a shared frame counter that increments on each tick over the range 0..FRAME_US-1 and wraps to 0.
REQ-017 SHALL drive pwm_out[i] high from a register while frame_cnt < cur_width[i], and low otherwise.
REQ-018 SHALL hold a table of NUM_GEST x NUM_CH 16-bit widths, reset to W_NEUTRAL for all entries.
REQ-019 SHALL, on cfg_we, write cfg_width clamped to [W_MIN, W_MAX] into entry (cfg_gest, cfg_ch), and ignore writes with cfg_gest >= NUM_GEST or cfg_ch >= NUM_CH.
REQ-020 SHALL, when gesture_valid and gesture < NUM_GEST, load target[i] = table[gesture][i] on the next clock edge (1-cycle latency).
REQ-021 SHALL, when gesture_valid and gesture >= NUM_GEST, load target[i] = W_NEUTRAL and pulse gest_err for one cycle.
REQ-022 SHALL, when cfg_we and gesture_valid coincide on the same entry, load target from the pre-write table value.
REQ-023 SHALL update cur_width only on the tick where frame_cnt == FRAME_US-1, so that widths never change mid-frame.
REQ-024 SHALL apply a per-frame update as follows: if |target-cur| <= STEP_US then cur = target; otherwise cur moves STEP_US toward target.
REQ-025 SHALL let a new target arriving mid-ramp replace the old one, with the ramp continuing from the current cur_width without any jump.
REQ-026 SHALL assert busy combinationally-registered as OR over i of (cur_width[i] != target[i]).
REQ-027 SHALL perform all width arithmetic in 17-bit signed form, with no wrap for any legal parameter set.

Reset
REQ-028 SHALL, while rst is high and independent of clk, force the prescaler and frame_cnt to 0, cur_width and target to W_NEUTRAL, the table to W_NEUTRAL, pwm_out to 0, busy to 0 and gest_err to 0.
REQ-029 SHALL, on rst release, start the first frame at frame_cnt 0; a reset asserted mid-frame truncates that pulse immediately.

Structure
REQ-030 SHALL place the default timing constants (W_MIN, W_MAX, W_NEUTRAL, FRAME_US, STEP_US) and the width_t typedef (16-bit) in package servo_pkg.
REQ-031 SHALL implement the per-channel ramp register plus comparator as sub-module servo_ramp_ch, instantiated NUM_CH times via generate, with the prescaler and frame counter shared in the top level.

Verification
REQ-032 SHALL cover this scenario: CLK_HZ=2_000_000, FRAME_US=100, W_* scaled to 20/80/50, STEP_US=5; after reset, all pwm_out are high for exactly 50 us (100 clocks) per frame, and busy=0.
REQ-033 SHALL cover this scenario: write gesture 1 with all channels at 70, then strobe gesture=1; target=70 one cycle later, cur goes 55, 60, 65, 70 on successive frame ends, and busy falls after the fourth update.
REQ-034 SHALL cover this scenario: strobe gesture=9 with NUM_GEST=8; gest_err pulses for 1 cycle and all targets become 50.
REQ-035 SHALL cover this scenario: cfg_width=200 is written; the read-back behaviour is 80 (clamped); with cfg_we and gesture_valid on the same entry in one cycle, target takes the old value.
REQ-036 SHALL cover this scenario: target is 70, and at cur=60 the gesture is changed to target 40; the next updates are 55, 50, 45, 40.
REQ-037 SHALL cover this scenario: rst is asserted mid-pulse; pwm_out drops within the same cycle, and outputs match the REQ-028 values after release.
